// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR    = 3'd0,
    ST_DATA   = 3'd1,
    ST_FINISH = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  localparam int HDR_BITS       = 32;
  localparam int BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port.
`default_nettype none

interface instr_mem_loader_if;

  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words; flags the 4th byte of each word.
`default_nettype none

module word_assembler
  import loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                byte_strobe,
  input  logic [7:0]          byte_in,
  input  logic                clear,
  output logic [HDR_BITS-1:0] word,
  output logic                word_complete
);

  localparam int ASM_BITS = HDR_BITS - 8;

  logic [1:0]          idx_q, idx_d;
  logic [ASM_BITS-1:0] asm_q, asm_d;

  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    if (clear) begin
      idx_d = '0;
      asm_d = '0;
    end else if (byte_strobe) begin
      idx_d = idx_q + 2'd1;
      asm_d = {asm_q[ASM_BITS-9:0], byte_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

  // The word includes the byte arriving this cycle, so the consumer can latch it
  // on the same edge that accepts the final byte.
  assign word          = {asm_q, byte_in};
  assign word_complete = byte_strobe && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// Boot loader: parses a length-prefixed big-endian byte stream into instruction
// memory writes and holds the core in reset until the image is complete.
`default_nettype none

module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  state_e      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] k_q, k_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        clear_d;

  logic                in_ready_w;
  logic                byte_strobe_w;
  logic [HDR_BITS-1:0] word_w;
  logic                word_complete_w;

  assign in_ready_w    = !reset && ((state_q == ST_HDR) || (state_q == ST_DATA));
  assign byte_strobe_w = bus.in_valid && in_ready_w;

  word_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .byte_strobe   (byte_strobe_w),
    .byte_in       (bus.in_byte),
    .clear         (clear_d),
    .word          (word_w),
    .word_complete (word_complete_w)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    error_d     = error_q;
    clear_d     = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (word_complete_w) begin
          n_d = word_w;
          k_d = '0;
          if (word_w == '0) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else if (word_w > 32'(DEPTH_WORDS)) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_complete_w) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE_ADDR + {k_q[29:0], 2'b00};
          mem_wdata_d = word_w;
          k_d         = k_q + 32'd1;
          if (k_q == n_q - 32'd1) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d    = ST_DONE;
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HDR;
          k_d        = '0;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          clear_d    = 1'b1;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HDR;
      n_q         <= '0;
      k_q         <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a write scoreboard per instance.
`default_nettype none

module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic cpu_hold0, done0, error0;
  logic cpu_hold1, done1, error1;

  int total = 0;
  int bad   = 0;
  int w0    = 0;
  int w1    = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  instr_mem_loader_if bus0();
  instr_mem_loader_if bus1();

  instr_mem_loader dut0 (
    .clk(clk), .reset(reset), .start(start0), .bus(bus0),
    .cpu_hold(cpu_hold0), .done(done0), .error(error0)
  );

  instr_mem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0100)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .bus(bus1),
    .cpu_hold(cpu_hold1), .done(done1), .error(error1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus0.mem_we === 1'b1) begin
      w0++;
      total++;
      if (q0.size() == 0) begin
        bad++;
        $error("FAIL wr0_unexpected observed=%h_%h expected=none", bus0.mem_addr, bus0.mem_wdata);
      end else begin
        logic [63:0] e;
        e = q0.pop_front();
        assert ({bus0.mem_addr, bus0.mem_wdata} === e) else begin
          bad++;
          $error("FAIL wr0 observed=%h_%h expected=%h_%h", bus0.mem_addr, bus0.mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
    if (bus1.mem_we === 1'b1) begin
      w1++;
      total++;
      if (q1.size() == 0) begin
        bad++;
        $error("FAIL wr1_unexpected observed=%h_%h expected=none", bus1.mem_addr, bus1.mem_wdata);
      end else begin
        logic [63:0] e;
        e = q1.pop_front();
        assert ({bus1.mem_addr, bus1.mem_wdata} === e) else begin
          bad++;
          $error("FAIL wr1 observed=%h_%h expected=%h_%h", bus1.mem_addr, bus1.mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  // Called just after a falling edge; returns just after the falling edge that
  // follows the accepting rising edge. in_valid is left high for back-to-back use.
  task automatic send_byte(input int sel, input logic [7:0] b);
    int n = 0;
    if (sel == 0) begin bus0.in_valid = 1'b1; bus0.in_byte = b; end
    else          begin bus1.in_valid = 1'b1; bus1.in_byte = b; end
    while (rdy(sel) !== 1'b1 && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic send_word(input int sel, input logic [31:0] w);
    send_byte(sel, w[31:24]);
    send_byte(sel, w[23:16]);
    send_byte(sel, w[15:8]);
    send_byte(sel, w[7:0]);
  endtask

  task automatic idle(input int sel);
    if (sel == 0) bus0.in_valid = 1'b0; else bus1.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic pulse_start0;
    start0 = 1'b1;
    @(posedge clk); @(negedge clk);
    start0 = 1'b0;
  endtask

  initial begin
    int base_w;
    logic [31:0] gw[2];
    bus0.in_valid = 1'b0; bus0.in_byte = 8'h00;
    bus1.in_valid = 1'b0; bus1.in_byte = 8'h00;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready_low", 32'(bus0.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready",  32'(bus0.in_ready), 32'd1);
    chk("rst_cpu_hold",  32'(cpu_hold0), 32'd1);
    chk("rst_done",      32'(done0), 32'd0);
    chk("rst_error",     32'(error0), 32'd0);
    chk("rst_mem_we",    32'(bus0.mem_we), 32'd0);
    chk("rst_addr0",     bus0.mem_addr, 32'h0);
    chk("rst_wdata",     bus0.mem_wdata, 32'h0);
    chk("rst_addr1",     bus1.mem_addr, 32'h100);
    @(negedge clk);

    // Basic load, continuous valid
    send_word(0, 32'd2);
    q0.push_back({32'h0, 32'hDEADBEEF});
    send_word(0, 32'hDEADBEEF);
    chk("basic_we1", 32'(bus0.mem_we), 32'd1);
    q0.push_back({32'h4, 32'h01234567});
    send_word(0, 32'h01234567);
    chk("basic_we2",     32'(bus0.mem_we), 32'd1);
    chk("finish_done",   32'(done0), 32'd0);
    chk("finish_hold",   32'(cpu_hold0), 32'd1);
    idle(0);
    chk("basic_done",    32'(done0), 32'd1);
    chk("basic_hold",    32'(cpu_hold0), 32'd0);
    chk("done_in_ready", 32'(bus0.in_ready), 32'd0);
    chk("basic_wcount",  32'(w0), 32'd2);

    // Restart with a byte presented on the start cycle: it must not be taken
    start0 = 1'b1; bus0.in_valid = 1'b1; bus0.in_byte = 8'hFF;
    @(posedge clk); @(negedge clk);
    start0 = 1'b0; bus0.in_valid = 1'b0;
    chk("restart_hold",  32'(cpu_hold0), 32'd1);
    chk("restart_ready", 32'(bus0.in_ready), 32'd1);
    chk("restart_done",  32'(done0), 32'd0);
    send_word(0, 32'd1);
    q0.push_back({32'h0, 32'hCAFEBABE});
    send_word(0, 32'hCAFEBABE);
    idle(0);
    chk("restart_done2", 32'(done0), 32'd1);

    // Gapped valid
    pulse_start0();
    base_w = w0;
    gw[0] = 32'hDEADBEEF; gw[1] = 32'h01234567;
    for (int i = 0; i < 4; i++) begin
      send_byte(0, 8'(32'd2 >> (8 * (3 - i))));
      idle(0);
    end
    for (int j = 0; j < 2; j++) begin
      q0.push_back({32'(4 * j), gw[j]});
      for (int i = 0; i < 4; i++) begin
        send_byte(0, gw[j][8*(3-i) +: 8]);
        idle(0);
      end
    end
    chk("gap_done",   32'(done0), 32'd1);
    chk("gap_wcount", 32'(w0 - base_w), 32'd2);

    // Zero-length header
    pulse_start0();
    base_w = w0;
    send_word(0, 32'd0);
    bus0.in_valid = 1'b0;
    chk("zero_done",   32'(done0), 32'd1);
    chk("zero_hold",   32'(cpu_hold0), 32'd0);
    chk("zero_we",     32'(bus0.mem_we), 32'd0);

    // Oversized header (DEPTH_WORDS + 1)
    pulse_start0();
    send_word(0, 32'd257);
    bus0.in_valid = 1'b0;
    chk("over_error", 32'(error0), 32'd1);
    chk("over_ready", 32'(bus0.in_ready), 32'd0);
    chk("over_hold",  32'(cpu_hold0), 32'd1);
    chk("over_done",  32'(done0), 32'd0);
    idle(0); idle(0);
    chk("hdr_wcount", 32'(w0 - base_w), 32'd0);

    // Reset in the middle of the second data word
    pulse_start0();
    chk("err_restart", 32'(error0), 32'd0);
    send_word(0, 32'd2);
    q0.push_back({32'h0, 32'h11112222});
    send_word(0, 32'h11112222);
    send_byte(0, 8'h33);
    send_byte(0, 8'h44);
    bus0.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstmid_ready", 32'(bus0.in_ready), 32'd0);
    chk("rstmid_hold",  32'(cpu_hold0), 32'd1);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstmid_addr", bus0.mem_addr, 32'h0);
    send_word(0, 32'd1);
    q0.push_back({32'h0, 32'h55667788});
    send_word(0, 32'h55667788);
    idle(0);
    chk("rstmid_done", 32'(done0), 32'd1);
    chk("total_w0",    32'(w0), 32'd7);

    // Non-zero base address on the second instance
    send_word(1, 32'd3);
    for (int j = 0; j < 3; j++) begin
      logic [31:0] d;
      d = 32'hA0B0C0D0 + 32'(j);
      q1.push_back({32'h100 + 32'(4 * j), d});
      send_word(1, d);
    end
    idle(1);
    chk("base_done",   32'(done1), 32'd1);
    chk("base_wcount", 32'(w1), 32'd3);

    idle(0); idle(1);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time writer for the instruction memory that the fetch path reads. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive word addresses through the memory write port. It holds the processor core in reset until the program image is fully written. It sits between the host/debug byte link and the instruction memory write port, and drives the core's reset via `cpu_hold`.

## Interface
- `DEPTH_WORDS`, default 256: instruction memory capacity in words; maximum legal image length.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first written word; must be 4-aligned.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle pulse; restarts loading from DONE or ERR. Ignored in other states.
- `in_valid`  in  1  `in_byte` is valid this cycle.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  single-cycle write strobe.
- `mem_addr`  out  32  byte address of the write; 4-aligned.
- `mem_wdata`  out  32  assembled word.
- `cpu_hold`  out  1  high holds the core (PC) in reset.
- `done`  out  1  image fully written.
- `error`  out  1  header length exceeded `DEPTH_WORDS`.

## Operation
- **Stream format:** 4-byte big-endian word count N, then N words of 4 bytes each, MSB first.
- **Byte transfer:** a byte transfers on every cycle where `in_valid && in_ready`. `in_valid` may drop at any time. The loader does not require the sender to hold a byte.
- **States:**
  - HDR: collect 4 bytes into the count.
  - DATA: collect words.
  - FINISH: last write in progress.
  - DONE: image loaded.
  - ERR: header length illegal.
- **Transitions:**
  - HDR to DONE when N == 0.
  - HDR to ERR when N > `DEPTH_WORDS`.
  - HDR to DATA otherwise.
  - DATA to FINISH when word N is accepted.
  - FINISH to DONE unconditionally.
  - DONE or ERR to HDR on `start`.
- **`in_ready`:** 1 exactly in HDR and DATA, and forced 0 while `reset` is high.
- **Byte index:** a 2-bit index counts bytes within a word and wraps 3 to 0. Each accepted byte shifts into the assembly register: `{asm[23:0], in_byte}`.
- **Word index:** k counts from 0 to N-1. `mem_addr = BASE_ADDR + 4*k`, computed in 32-bit arithmetic; wrap is impossible because N ≤ `DEPTH_WORDS`.
- **Back-to-back bytes:** the write data and address are latched into dedicated output registers. The next word's assembly therefore proceeds in the same cycle as the write.
- **Status outputs:**
  - `cpu_hold` = 0 only in DONE.
  - `done` = 1 only in DONE.
  - `error` = 1 only in ERR.
- **`start` in DONE:** reasserts `cpu_hold` on the next cycle.

## Timing
- **Reset values:** state HDR; `cpu_hold` 1; `done` 0; `error` 0; `mem_we` 0; `mem_addr` `BASE_ADDR`; `mem_wdata` 0; byte index 0; k 0.
- **Write latency:** 4th byte of a word accepted at edge T gives `mem_we` = 1 with valid addr/data during cycle T+1 for exactly one cycle.
- **Completion:** last byte accepted at T gives FINISH during T+1 (with `mem_we`), then DONE, `done` = 1 and `cpu_hold` = 0 from T+2.
- **Header errors:** 4th header byte at T gives ERR or DONE (for N == 0) during T+1. No `mem_we` pulse.
- **Throughput:** 1 byte per cycle sustained. No bubbles between words.
- **Reset mid-load:** asynchronously clears everything to reset values. The partial image is abandoned, and already-written words are not erased.
- **`start` in HDR/DATA/FINISH:** ignored.
- **`start` with `in_valid` in DONE:** the byte is not accepted that cycle, because `in_ready` = 0 until the state is HDR.

## Structure
- Shared package `loader_pkg`:
  - state enum (HDR, DATA, FINISH, DONE, ERR);
  - header width constant (32);
  - bytes-per-word constant (4).
- Sub-module `word_assembler`:
  - inputs: byte strobe, byte, clear;
  - outputs: 32-bit word and `word_complete`;
  - contains the 2-bit index and shift register.
- The FSM, address counter and output registers stay in `instr_mem_loader`.

## Test plan
- **Basic load:** stream 00 00 00 02, DE AD BE EF, 01 23 45 67 with continuous valid. Expect writes (0x0, 0xDEADBEEF) and (0x4, 0x01234567), each 1 cycle after its 4th byte. `done` = 1 and `cpu_hold` = 0 two cycles after the last byte.
- **Gapped valid:** same image with `in_valid` toggling every other cycle. Expect identical write values and addresses, and exactly 2 `mem_we` pulses.
- **Zero and oversized headers:**
  - Header 0: expect `done` the cycle after the 4th byte and no writes.
  - Header 257 with `DEPTH_WORDS` = 256: expect `error` = 1, `in_ready` = 0, `cpu_hold` = 1, no writes.
- **Reset mid-word:** assert `reset` after 6 data bytes. Expect immediate `in_ready` = 0 and `cpu_hold` = 1. After release, a fresh header plus 1 word writes to `BASE_ADDR`.
- **Restart:** after DONE, pulse `start`. Expect `cpu_hold` = 1 and `in_ready` = 1 next cycle. A new 1-word image writes to `BASE_ADDR`.
- **Non-zero base:** `BASE_ADDR` = 0x100 with 3 words. Expect addresses 0x100, 0x104, 0x108.
